// File: rtl/wb_port_arbiter_if.sv
// Bundle of writeback requests, destination reservations, hazard checks and the
// register-file write port shared by the arbiter and whatever drives it.
interface wb_port_arbiter_if;
  logic        req0_valid;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req0_ready;

  logic        req1_valid;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        req1_ready;

  logic        rsv_valid;
  logic [4:0]  rsv_addr;

  logic [4:0]  chk_addr1;
  logic [4:0]  chk_addr2;
  logic        hazard1;
  logic        hazard2;

  logic        we;
  logic [4:0]  write_addr;
  logic [31:0] write_instr;

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  rsv_valid, rsv_addr, chk_addr1, chk_addr2,
    output req0_ready, req1_ready, hazard1, hazard2,
    output we, write_addr, write_instr
  );

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output rsv_valid, rsv_addr, chk_addr1, chk_addr2,
    input  req0_ready, req1_ready, hazard1, hazard2,
    input  we, write_addr, write_instr
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Two-requester register-file write port arbiter: requester 0 has priority, requester 1
// is forced through after STARVE_MAX denied cycles, and reserved destinations raise hazards.
module wb_port_arbiter #(
  parameter int unsigned STARVE_MAX = 3
) (
  input logic              clk,
  input logic              rst,
  wb_port_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;
  logic [31:0]      pending;
  logic             we_q;
  logic [4:0]       waddr_q;
  logic [31:0]      wdata_q;

  logic             force1;
  logic             grant0;
  logic             grant1;
  logic [4:0]       win_addr;
  logic [31:0]      win_data;
  logic             win_we;
  logic [31:0]      pending_nxt;

  always_comb begin
    // NOTE: every signal written here gets a value on every path first, so no latch is inferred.
    force1      = bus.req1_valid && (starve_cnt == CNT_MAX);
    grant1      = !rst && bus.req1_valid && (!bus.req0_valid || force1);
    grant0      = !rst && bus.req0_valid && !grant1;
    win_addr    = grant1 ? bus.req1_addr : bus.req0_addr;
    win_data    = grant1 ? bus.req1_data : bus.req0_data;
    // Register 0 is hardwired; a grant to it is acknowledged but never written.
    win_we      = (grant0 || grant1) && (win_addr != 5'd0);

    // Applying the set after the clear makes a same-edge reservation win.
    pending_nxt = pending;
    if (grant1) pending_nxt[bus.req1_addr] = 1'b0;
    if (bus.rsv_valid) pending_nxt[bus.rsv_addr] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      pending    <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      pending <= pending_nxt;

      if (bus.req1_valid && !grant1) begin
        if (starve_cnt != CNT_MAX) starve_cnt <= starve_cnt + CNT_W'(1);
      end else begin
        starve_cnt <= '0;
      end

      we_q <= win_we;
      if (win_we) begin
        waddr_q <= win_addr;
        wdata_q <= win_data;
      end
    end
  end

  assign bus.req0_ready  = grant0;
  assign bus.req1_ready  = grant1;
  assign bus.hazard1     = !rst && pending[bus.chk_addr1];
  assign bus.hazard2     = !rst && pending[bus.chk_addr2];
  assign bus.we          = we_q;
  assign bus.write_addr  = waddr_q;
  assign bus.write_instr = wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: the driver checks grants and hazards and queues
// expected writes; an independent monitor matches every we pulse against that queue.
module tb_wb_port_arbiter;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  wr_t  sb[$];
  wr_t  mon_e;

  wb_port_arbiter_if bus ();

  wb_port_arbiter #(.STARVE_MAX(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic rv, input logic [4:0] ra);
    bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
    bus.rsv_valid  = rv; bus.rsv_addr  = ra;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
  endtask

  // Inputs change 1 time unit after the active edge.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_grant(input string tag, input logic g0, input logic g1);
    check({tag, "_ready0"}, bus.req0_ready, g0);
    check({tag, "_ready1"}, bus.req1_ready, g1);
  endtask

  // Called before the edge that samples the grant; the write shows on we after that edge.
  task automatic expect_write(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    if (a != 5'd0) begin
      e.addr = a; e.data = d; e.cyc = cyc + 1;
      sb.push_back(e);
    end
  endtask

  // Monitor: every we pulse must match the oldest queued write, in the expected cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.we) begin
        if (sb.size() == 0) begin
          check("we_unexpected", bus.we, 1'b0);
        end else begin
          mon_e = sb.pop_front();
          check("wr_addr", bus.write_addr, mon_e.addr);
          check("wr_data", bus.write_instr, mon_e.data);
          check("wr_cycle", cyc, mon_e.cyc);
        end
      end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
        check("we_missing", bus.we, 1'b1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] r1_wins;
    logic       w1;

    // Reset state, with both requesters valid to show grants are suppressed.
    idle();
    bus.chk_addr1 = 5'd0;
    bus.chk_addr2 = 5'd0;
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd5;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd6;
    #2;
    chk_grant("rst", 1'b0, 1'b0);
    check("rst_we", bus.we, 1'b0);
    check("rst_waddr", bus.write_addr, 5'd0);
    check("rst_wdata", bus.write_instr, 32'h0);
    check("rst_hz1", bus.hazard1, 1'b0);
    check("rst_hz2", bus.hazard2, 1'b0);
    @(negedge clk);
    idle();
    rst = 1'b0;

    // Single requester-0 write, latency one cycle, then we drops and address holds.
    next(); drive(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0); #3;
    chk_grant("r0only", 1'b1, 1'b0);
    expect_write(5'd5, 32'h1234_5678);
    next(); idle(); #3;
    chk_grant("r0only_idle", 1'b0, 1'b0);
    check("r0only_we", bus.we, 1'b1);
    next(); idle(); #3;
    check("r0only_we_drop", bus.we, 1'b0);
    check("r0only_addr_hold", bus.write_addr, 5'd5);

    // Both valid continuously: requester 1 wins every fourth cycle.
    r1_wins = 8'b1000_1000;
    for (int i = 0; i < 8; i++) begin
      next();
      drive(1'b1, 5'd1, 32'h100 + 32'(i), 1'b1, 5'd2, 32'h200 + 32'(i), 1'b0, 5'd0);
      #3;
      w1 = r1_wins[i];
      chk_grant($sformatf("starve%0d", i), !w1, w1);
      if (w1) expect_write(5'd2, 32'h200 + 32'(i));
      else    expect_write(5'd1, 32'h100 + 32'(i));
    end
    next(); idle();

    // Reservation of 7 raises hazard1 next cycle; it drops with the req1 write.
    bus.chk_addr1 = 5'd7;
    next(); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7); #3;
    check("rsv7_hz_before", bus.hazard1, 1'b0);
    next(); idle(); #3;
    check("rsv7_hz_set", bus.hazard1, 1'b1);
    next(); drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h0000_00A5, 1'b0, 5'd0); #3;
    chk_grant("wb7", 1'b0, 1'b1);
    check("wb7_hz_grant_cycle", bus.hazard1, 1'b1);
    expect_write(5'd7, 32'h0000_00A5);
    next(); idle(); #3;
    check("wb7_we", bus.we, 1'b1);
    check("wb7_hz_clear", bus.hazard1, 1'b0);

    // Same-edge set and clear of 9: the reservation survives.
    bus.chk_addr2 = 5'd9;
    next(); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
    next(); drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h0000_0909, 1'b1, 5'd9); #3;
    chk_grant("setclr9", 1'b0, 1'b1);
    expect_write(5'd9, 32'h0000_0909);
    next(); idle(); #3;
    check("setclr9_hz", bus.hazard2, 1'b1);
    // A requester-0 write to a reserved register leaves the reservation alone.
    next(); drive(1'b1, 5'd9, 32'h0000_0099, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0); #3;
    chk_grant("r0_to_9", 1'b1, 1'b0);
    expect_write(5'd9, 32'h0000_0099);
    next(); idle(); #3;
    check("r0_to_9_hz", bus.hazard2, 1'b1);
    next(); drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h0000_0919, 1'b0, 5'd0); #3;
    chk_grant("clr9", 1'b0, 1'b1);
    expect_write(5'd9, 32'h0000_0919);
    next(); idle(); #3;
    check("clr9_hz", bus.hazard2, 1'b0);

    // Register 0: acknowledged but never written, never reserved.
    bus.chk_addr1 = 5'd0;
    next(); drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0); #3;
    chk_grant("addr0", 1'b1, 1'b0);
    next(); idle(); #3;
    check("addr0_we", bus.we, 1'b0);
    check("addr0_hz", bus.hazard1, 1'b0);

    // Asynchronous reset between edges while pending[3] is set and we is high.
    bus.chk_addr1 = 5'd3;
    next(); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
    next(); drive(1'b1, 5'd4, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0); #3;
    chk_grant("pre_rst", 1'b1, 1'b0);
    check("pre_rst_hz", bus.hazard1, 1'b1);
    expect_write(5'd4, 32'hDEAD_BEEF);
    next(); idle();
    @(negedge clk); #1;
    check("pre_rst_we", bus.we, 1'b1);
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd4;
    rst = 1'b1;
    #1;
    check("arst_we", bus.we, 1'b0);
    check("arst_waddr", bus.write_addr, 5'd0);
    check("arst_wdata", bus.write_instr, 32'h0);
    check("arst_hz", bus.hazard1, 1'b0);
    chk_grant("arst", 1'b0, 1'b0);
    next();
    check("arst_hold_we", bus.we, 1'b0);
    // Release between edges; a grant is possible on the very next edge.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'hCAFE_0003, 1'b0, 5'd0);
    rst = 1'b0;
    #1;
    chk_grant("post_rst", 1'b0, 1'b1);
    check("post_rst_hz", bus.hazard1, 1'b0);
    expect_write(5'd3, 32'hCAFE_0003);
    next(); idle(); #3;
    check("post_rst_we", bus.we, 1'b1);

    repeat (3) next();
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
